// File: rtl/proc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory side.
// master = controller, slave = datapath.
interface proc_ctrl_if;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic        alu_zero;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        ir_load;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_we;
  logic        wb_sel;
  logic        alu_src;
  logic [2:0]  state;
  logic        halted;
  logic        error;
  logic [15:0] retired;

  modport master (
    input  opcode, mem_ready, alu_zero,
    output pc_en, pc_sel, ir_load, mem_req, mem_we, mem_addr_sel,
    output reg_we, wb_sel, alu_src, state, halted, error, retired
  );

  modport slave (
    output opcode, mem_ready, alu_zero,
    input  pc_en, pc_sel, ir_load, mem_req, mem_we, mem_addr_sel,
    input  reg_we, wb_sel, alu_src, state, halted, error, retired
  );
endinterface

// File: rtl/proc_ctrl.sv
// Multi-cycle processor control FSM: fetch/decode/exec/mem/writeback sequencing with
// memory-wait timeout, halt/fault terminal states and a retired-instruction counter.
module proc_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  proc_ctrl_if.master  bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StFault  = 3'd6
  } state_t;

  state_t          state_q;
  logic [3:0]      op_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     retired_q;

  logic is_alu, is_load, is_store, is_beq, is_jmp, is_halt, is_nop;
  logic timeout_hit, retire;

  always_comb begin
    is_alu   = ~op_q[3];
    is_load  = (op_q == 4'h8);
    is_store = (op_q == 4'h9);
    is_beq   = (op_q == 4'hA);
    is_jmp   = (op_q == 4'hB);
    is_halt  = (op_q == 4'hF);
    is_nop   = op_q[3] & op_q[2] & ~is_halt;
  end

  // Last permitted wait cycle; a ready on this cycle still completes normally.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    retire = 1'b0;
    case (state_q)
      StExec:  retire = is_beq | is_jmp | is_nop | is_halt;
      StMem:   retire = bus.mem_ready & is_store;
      StWb:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= 4'h0;
      cnt_q     <= '0;
      retired_q <= 16'h0000;
    end else begin
      // Outside the memory-wait states the counter rests at zero, so entry always starts clean.
      cnt_q <= '0;
      if (retire) retired_q <= retired_q + 16'd1;
      case (state_q)
        StFetch: begin
          if (bus.mem_ready) begin
            state_q <= StDecode;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) state_q <= StFault;
          end
        end
        StDecode: begin
          op_q    <= bus.opcode;
          state_q <= StExec;
        end
        StExec: begin
          if (is_alu)                   state_q <= StWb;
          else if (is_load || is_store) state_q <= StMem;
          else if (is_halt)             state_q <= StHalt;
          else                          state_q <= StFetch;
        end
        StMem: begin
          if (bus.mem_ready) begin
            state_q <= is_store ? StFetch : StWb;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) state_q <= StFault;
          end
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        StFault: state_q <= StFault;
        default: state_q <= StFault;
      endcase
    end
  end

  always_comb begin
    bus.pc_en        = 1'b0;
    bus.pc_sel       = 2'b00;
    bus.ir_load      = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = 1'b0;
    bus.alu_src      = 1'b0;
    bus.halted       = 1'b0;
    bus.error        = 1'b0;
    bus.state        = state_q;
    bus.retired      = retired_q;
    // Strobes are held off for the whole reset window, not just after the first edge.
    if (!reset) begin
      case (state_q)
        StFetch: begin
          bus.mem_req = 1'b1;
          bus.ir_load = bus.mem_ready;
          bus.pc_en   = bus.mem_ready;
        end
        StExec: begin
          bus.alu_src = is_load | is_store;
          if (is_beq) begin
            bus.pc_en  = bus.alu_zero;
            bus.pc_sel = 2'b01;
          end else if (is_jmp) begin
            bus.pc_en  = 1'b1;
            bus.pc_sel = 2'b10;
          end
        end
        StMem: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = is_store;
          // Keep the immediate selected so the effective address stays stable while waiting.
          bus.alu_src      = 1'b1;
        end
        StWb: begin
          bus.reg_we = 1'b1;
          bus.wb_sel = is_load;
        end
        StHalt:  bus.halted = 1'b1;
        StFault: bus.error  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
